// File: rtl/msg_deframer_pkg.sv
// Shared types and default sizes for the length-prefixed byte-stream deframer.
package msg_deframer_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int LEN_W_DEF   = 16;
  localparam int MAX_LEN_DEF = 1500;

  typedef enum logic [1:0] {
    HDR_HI,
    HDR_LO,
    PAYLOAD,
    DROP
  } state_t;

endpackage

// File: rtl/msg_deframer_skid.sv
// Two-entry register buffer between the deframer FSM and the AXI-stream master.
// s_ready depends only on the fill count, never on m_ready.
module axis_skid_buf
  import msg_deframer_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic [1:0]   count
);

  // Handshake: a beat moves on a side when its valid and ready are both high
  // at the rising edge; valid/data hold until that happens.
  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   cnt;
  logic         push;
  logic         pop;

  assign s_ready = (cnt != 2'd2);
  assign m_valid = (cnt != 2'd0);
  assign m_data  = mem[rd_ptr];
  assign count   = cnt;
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/msg_deframer.sv
// Strips a 2-byte big-endian length header and forwards the payload as an
// AXI-stream with tlast; pulses cnt_clear so the downstream counter restarts.
module msg_deframer
  import msg_deframer_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [DATA_W-1:0] s_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic [LEN_W-1:0]  m_tlen,
  output logic              cnt_clear,
  output logic              len_err,
  output logic              zero_len
);

  // Handshake: s_* and m_* beats transfer on a rising edge where valid and
  // ready are both high; the master side holds valid/data/last until taken.
  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   len_hi;
  logic [LEN_W-1:0]    remain;
  logic [LEN_W-1:0]    hdr_len;
  logic [LEN_W-1:0]    pend_len;
  logic                pend_vld;

  logic                ready_c;
  logic                push;
  logic                hdr_zero;
  logic                hdr_big;
  logic                hdr_ok;
  logic                hi_take;
  logic                defer;
  logic                tlast_pop;

  logic                buf_ready;
  logic [1:0]          buf_cnt;
  logic [DATA_W:0]     buf_out;

  assign hdr_len   = LEN_W'({len_hi, s_tdata});
  assign hi_take   = (state == HDR_HI) && s_tvalid && ready_c;
  assign tlast_pop = m_tvalid && m_tready && m_tlast;
  // Bytes of the previous message still buffered (and not leaving this cycle)
  // mean the new length must wait until that message's last byte is taken.
  assign defer     = (buf_cnt == 2'd2) || ((buf_cnt == 2'd1) && !(m_tvalid && m_tready));
  assign s_tready  = ready_c && !rst;
  assign m_tdata   = buf_out[DATA_W-1:0];
  assign m_tlast   = buf_out[DATA_W];

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    push      = 1'b0;
    hdr_zero  = 1'b0;
    hdr_big   = 1'b0;
    hdr_ok    = 1'b0;
    case (state)
      HDR_HI: begin
        // Only one deferred header can be parked; hold off the next one.
        ready_c = !pend_vld;
        if (s_tvalid && ready_c) state_nxt = HDR_LO;
      end
      HDR_LO: begin
        ready_c = 1'b1;
        if (s_tvalid) begin
          if (hdr_len == '0) begin
            hdr_zero  = 1'b1;
            state_nxt = HDR_HI;
          end else if (hdr_len > LEN_W'(MAX_LEN)) begin
            hdr_big   = 1'b1;
            state_nxt = DROP;
          end else begin
            hdr_ok    = 1'b1;
            state_nxt = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        ready_c = buf_ready;
        if (s_tvalid && buf_ready) begin
          push = 1'b1;
          if (remain == LEN_W'(1)) state_nxt = HDR_HI;
        end
      end
      DROP: begin
        ready_c = 1'b1;
        if (s_tvalid && (remain == LEN_W'(1))) state_nxt = HDR_HI;
      end
      default: state_nxt = HDR_HI;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HDR_HI;
      len_hi    <= '0;
      remain    <= '0;
      m_tlen    <= '0;
      pend_len  <= '0;
      pend_vld  <= 1'b0;
      cnt_clear <= 1'b0;
      len_err   <= 1'b0;
      zero_len  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt_clear <= 1'b0;
      len_err   <= hdr_big;
      zero_len  <= hdr_zero;
      if (hi_take) len_hi <= s_tdata;
      if (hdr_big || hdr_ok) begin
        remain <= hdr_len;
      end else if (push || ((state == DROP) && s_tvalid)) begin
        remain <= remain - LEN_W'(1);
      end
      if (hdr_ok) begin
        if (defer) begin
          pend_vld <= 1'b1;
          pend_len <= hdr_len;
        end else begin
          m_tlen    <= hdr_len;
          cnt_clear <= 1'b1;
        end
      end else if (pend_vld && tlast_pop) begin
        m_tlen    <= pend_len;
        cnt_clear <= 1'b1;
        pend_vld  <= 1'b0;
      end
    end
  end

  axis_skid_buf #(.W(DATA_W + 1)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_valid (push),
    .s_ready (buf_ready),
    .s_data  ({remain == LEN_W'(1), s_tdata}),
    .m_valid (m_tvalid),
    .m_ready (m_tready),
    .m_data  (buf_out),
    .count   (buf_cnt)
  );

endmodule
